// File: rtl/reg_wb_queue_if.sv
// Register-file writeback bus: in-order source A, handshaked source B, and the
// registered write port that feeds the 32x32 register file.
interface reg_wb_queue_if #(
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic [4:0]        a_reg;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [4:0]        b_reg;
   logic [DATA_W-1:0] b_data;
   logic              RegWrite;
   logic [4:0]        write_reg;
   logic [DATA_W-1:0] write_data;

   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  b_ready, RegWrite, write_reg, write_data
   );

   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output b_ready, RegWrite, write_reg, write_data
   );
endinterface

// File: rtl/reg_wb_queue.sv
// Writeback front-end: merges priority source A and FIFO-buffered source B onto
// the register file's single write port, filters r0 writes, exposes a busy scoreboard.
module reg_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   reg_wb_queue_if.slave            bus,
   input  logic [4:0]               chk_reg_1,
   input  logic [4:0]               chk_reg_2,
   output logic                     chk_busy_1,
   output logic                     chk_busy_2,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         drop_count
);
   localparam int AW = $clog2(DEPTH);

   logic [4:0]        q_reg  [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       level;

   logic              out_we;
   logic [4:0]        out_reg;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  drops;

   logic              b_fire;
   logic              push;
   logic              pop;
   logic              a_issue;
   logic              a_drop;
   logic              b_drop;
   logic [CNT_W:0]    drop_sum;
   logic [CNT_W-1:0]  drop_next;
   logic [DEPTH-1:0]  entry_valid;
   logic [DEPTH-1:0]  hit_1;
   logic [DEPTH-1:0]  hit_2;

   // No pop credit in ready: a full FIFO always stalls B for a cycle.
   assign bus.b_ready = rst_n && (level < (AW+1)'(DEPTH));
   assign b_fire      = bus.b_valid && bus.b_ready;
   assign push        = b_fire && (bus.b_reg != 5'd0);
   assign b_drop      = b_fire && (bus.b_reg == 5'd0);
   assign a_issue     = bus.a_valid && (bus.a_reg != 5'd0);
   assign a_drop      = bus.a_valid && (bus.a_reg == 5'd0);
   assign pop         = !a_issue && (level != '0);

   assign drop_sum  = {1'b0, drops} + (CNT_W+1)'(a_drop) + (CNT_W+1)'(b_drop);
   assign drop_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [AW-1:0] offset;
         // Slot is occupied when its distance from the head is below the level.
         assign offset          = AW'(gi) - rd_ptr;
         assign entry_valid[gi] = ({1'b0, offset} < level);
         assign hit_1[gi]       = entry_valid[gi] && (q_reg[gi] == chk_reg_1);
         assign hit_2[gi]       = entry_valid[gi] && (q_reg[gi] == chk_reg_2);
      end
   endgenerate

   assign chk_busy_1 = (chk_reg_1 != 5'd0) &&
                       ((|hit_1) || (out_we && (out_reg == chk_reg_1)));
   assign chk_busy_2 = (chk_reg_2 != 5'd0) &&
                       ((|hit_2) || (out_we && (out_reg == chk_reg_2)));

   always_ff @(posedge clk) begin
      if (push) begin
         q_reg[wr_ptr]  <= bus.b_reg;
         q_data[wr_ptr] <= bus.b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         out_we   <= 1'b0;
         out_reg  <= 5'd0;
         out_data <= '0;
         drops    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         out_we <= a_issue || pop;
         if (a_issue) begin
            out_reg  <= bus.a_reg;
            out_data <= bus.a_data;
         end else if (pop) begin
            out_reg  <= q_reg[rd_ptr];
            out_data <= q_data[rd_ptr];
         end
         drops <= drop_next;
      end
   end

   assign bus.RegWrite   = out_we;
   assign bus.write_reg  = out_reg;
   assign bus.write_data = out_data;
   assign fifo_level     = level;
   assign drop_count     = drops;
endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: latency, FIFO order/backpressure, r0 filtering,
// saturation, mid-drain reset and the busy scoreboard.
module tb_reg_wb_queue;
   logic       clk;
   logic       rst_n;
   logic [4:0] chk_reg_1;
   logic [4:0] chk_reg_2;
   logic       chk_busy_1;
   logic       chk_busy_2;
   logic [2:0] fifo_level;
   logic [7:0] drop_count;

   int vectors;
   int miscompares;

   reg_wb_queue_if #(.DATA_W(32)) bus ();

   reg_wb_queue #(.DEPTH(4), .DATA_W(32), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .chk_reg_1  (chk_reg_1),
      .chk_reg_2  (chk_reg_2),
      .chk_busy_1 (chk_busy_1),
      .chk_busy_2 (chk_busy_2),
      .fifo_level (fifo_level),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          q_r[$];
      logic [31:0] q_d[$];
      int          r;
      logic [31:0] d;
      int          exp_r;
      logic [31:0] exp_d;
      logic        popped;
      logic        exp_ready;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.a_valid = 1'b0;
      bus.a_reg   = 5'd0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_reg   = 5'd0;
      bus.b_data  = '0;
      chk_reg_1   = 5'd0;
      chk_reg_2   = 5'd0;

      // Reset state
      tick();
      tick();
      check("rst RegWrite", bus.RegWrite, 0);
      check("rst write_reg", bus.write_reg, 0);
      check("rst write_data", bus.write_data, 0);
      check("rst fifo_level", fifo_level, 0);
      check("rst drop_count", drop_count, 0);
      check("rst b_ready", bus.b_ready, 0);
      rst_n = 1'b1;
      tick();
      check("post-rst b_ready", bus.b_ready, 1);

      // Source A single write
      bus.a_valid = 1'b1;
      bus.a_reg   = 5'd5;
      bus.a_data  = 32'hDEADBEEF;
      tick();
      bus.a_valid = 1'b0;
      check("A RegWrite", bus.RegWrite, 1);
      check("A write_reg", bus.write_reg, 5);
      check("A write_data", bus.write_data, 64'hDEADBEEF);
      tick();
      check("A idle RegWrite", bus.RegWrite, 0);
      check("A idle write_reg held", bus.write_reg, 5);

      // Four B pushes while A holds the port with reg 3
      bus.a_valid = 1'b1;
      bus.a_reg   = 5'd3;
      bus.a_data  = 32'h3333;
      for (int i = 0; i < 4; i++) begin
         bus.b_valid = 1'b1;
         bus.b_reg   = 5'(8 + i);
         bus.b_data  = 32'h80 + 32'(i) * 32'h10;
         tick();
      end
      bus.b_valid = 1'b0;
      chk_reg_1   = 5'd10;
      chk_reg_2   = 5'd3;
      #1;
      check("fill level", fifo_level, 4);
      check("fill b_ready", bus.b_ready, 0);
      check("busy r10 queued", chk_busy_1, 1);
      check("busy r3 on port", chk_busy_2, 1);
      check("A wins write_reg", bus.write_reg, 3);
      tick();
      tick();
      bus.a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain RegWrite", bus.RegWrite, 1);
         check("drain write_reg", bus.write_reg, 64'(8 + i));
         check("drain write_data", bus.write_data, 64'(32'h80 + 32'(i) * 32'h10));
         check("drain level", fifo_level, 64'(3 - i));
      end
      tick();
      check("drained RegWrite", bus.RegWrite, 0);
      check("busy r10 cleared", chk_busy_1, 0);

      // Full FIFO, A idle, B held: scoreboard
      bus.a_valid = 1'b1;
      bus.a_reg   = 5'd1;
      for (int i = 0; i < 4; i++) begin
         r = $urandom_range(1, 31);
         d = $urandom;
         bus.b_valid = 1'b1;
         bus.b_reg   = 5'(r);
         bus.b_data  = d;
         q_r.push_back(r);
         q_d.push_back(d);
         tick();
      end
      bus.a_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         exp_ready = (q_r.size() < 4);
         check("sb b_ready", bus.b_ready, 64'(exp_ready));
         r = $urandom_range(1, 31);
         d = $urandom;
         bus.b_valid = 1'b1;
         bus.b_reg   = 5'(r);
         bus.b_data  = d;
         popped = (q_r.size() > 0);
         exp_r  = 0;
         exp_d  = '0;
         if (popped) begin
            exp_r = q_r.pop_front();
            exp_d = q_d.pop_front();
         end
         if (exp_ready) begin
            q_r.push_back(r);
            q_d.push_back(d);
         end
         tick();
         check("sb RegWrite", bus.RegWrite, 64'(popped));
         if (popped) begin
            check("sb write_reg", bus.write_reg, 64'(exp_r));
            check("sb write_data", bus.write_data, 64'(exp_d));
         end
         check("sb level", fifo_level, 64'(q_r.size()));
      end
      bus.b_valid = 1'b0;
      for (int i = 0; i < 8 && q_r.size() > 0; i++) begin
         exp_r = q_r.pop_front();
         exp_d = q_d.pop_front();
         tick();
         check("sb tail write_reg", bus.write_reg, 64'(exp_r));
         check("sb tail write_data", bus.write_data, 64'(exp_d));
      end
      tick();
      check("sb empty level", fifo_level, 0);
      check("sb empty RegWrite", bus.RegWrite, 0);

      // Zero-register filtering and saturation
      chk_reg_1   = 5'd0;
      bus.a_valid = 1'b1;
      bus.a_reg   = 5'd0;
      bus.a_data  = 32'h1234;
      bus.b_valid = 1'b1;
      bus.b_reg   = 5'd0;
      bus.b_data  = 32'h5678;
      #1;
      check("r0 b_ready", bus.b_ready, 1);
      tick();
      check("r0 RegWrite", bus.RegWrite, 0);
      check("r0 drop +2", drop_count, 2);
      check("r0 level", fifo_level, 0);
      check("r0 busy", chk_busy_1, 0);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (i % 50 == 0) check("r0 loop busy", chk_busy_1, 0);
      end
      check("drop saturated", drop_count, 255);
      check("r0 loop RegWrite", bus.RegWrite, 0);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;

      // Reset pulse mid-drain
      bus.a_valid = 1'b1;
      bus.a_reg   = 5'd2;
      for (int i = 0; i < 3; i++) begin
         bus.b_valid = 1'b1;
         bus.b_reg   = 5'(12 + i);
         bus.b_data  = 32'hC0 + 32'(i);
         tick();
      end
      bus.b_valid = 1'b0;
      bus.a_valid = 1'b0;
      tick();
      check("pre-rst write_reg", bus.write_reg, 12);
      check("pre-rst level", fifo_level, 2);
      rst_n = 1'b0;
      tick();
      check("mid-rst RegWrite", bus.RegWrite, 0);
      check("mid-rst write_reg", bus.write_reg, 0);
      check("mid-rst level", fifo_level, 0);
      check("mid-rst drop_count", drop_count, 0);
      check("mid-rst b_ready", bus.b_ready, 0);
      rst_n = 1'b1;
      #1;
      check("release b_ready", bus.b_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("discarded RegWrite", bus.RegWrite, 0);
         check("discarded level", fifo_level, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/reg_wb_queue.md
# reg_wb_queue

Writeback front-end for the 32x32 register file. It merges two write sources into the file's single write port. Source A is the in-order pipeline writeback; it has priority and no backpressure. Source B is the long-latency unit (mult/div); it uses a valid/ready handshake and is buffered in a small FIFO. The block also filters writes to register 0 and exposes a busy scoreboard so the hazard unit can stall reads of registers with queued writes.

## Interface
Parameters:
- DEPTH, 4: source-B FIFO entries (power of 2, ≥2)
- DATA_W, 32: write data width
- CNT_W, 8: dropped-write counter width

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- a_valid  in  1  source A write request, must be accepted this cycle
- a_reg  in  5  source A destination register
- a_data  in  DATA_W  source A write data
- b_valid  in  1  source B write request
- b_ready  out  1  source B can be accepted
- b_reg  in  5  source B destination register
- b_data  in  DATA_W  source B write data
- RegWrite  out  1  register-file write enable (registered)
- write_reg  out  5  register-file write address (registered)
- write_data  out  DATA_W  register-file write data (registered)
- chk_reg_1, chk_reg_2  in  5  registers queried by the hazard unit
- chk_busy_1, chk_busy_2  out  1  the queried register has a write pending
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_count  out  CNT_W  saturating count of writes to register 0 that were discarded

## Operation
- Output stage: one register holding {RegWrite, write_reg, write_data}. It is loaded every cycle.
- Output stage selection, per cycle, in priority order:
  - a_valid && a_reg!=0: load A.
  - Else, if the FIFO is not empty: pop the head and load it.
  - Else: RegWrite=0; write_reg and write_data hold their values.
- Source B handshake: b_ready = rst_n && (fifo_level < DEPTH). A transfer occurs when b_valid && b_ready at posedge.
  - b_ready does not include same-cycle pop credit; a full FIFO stalls B for at least one cycle.
- Transferred B entry with b_reg!=0: pushed at the tail.
- Transferred B entry with b_reg==0: handshake completes, nothing is enqueued, drop_count increments.
- a_valid with a_reg==0: not issued, drop_count increments, and a FIFO pop may proceed that same cycle.
- drop_count:
  - Adds 0, 1 or 2 per cycle (an A drop and a B drop can occur together).
  - Saturates at 2^CNT_W-1, never wraps.
- Push and pop in the same cycle: both take effect; fifo_level is unchanged.
- Pointers wrap modulo DEPTH.
- FIFO order is strict; B writes retire in acceptance order.
- chk_busy_n (combinational) = (chk_reg_n!=0) && (a valid FIFO entry has reg==chk_reg_n, or RegWrite && write_reg==chk_reg_n).
  - Source A inputs are not included.
- Ordering between A and B writes to the same register is not arbitrated. The issuing pipeline guarantees it by stalling on chk_busy.

## Timing
- Source-A latency: request in cycle t → RegWrite/write_reg/write_data valid during cycle t+1 → register file written at end of t+1.
- Source-B latency: push at edge t, FIFO previously empty, a_valid low in cycle t+1 → output valid during cycle t+2.
- Sustained A traffic starves B indefinitely. FIFO fills, then b_ready holds low.
- Reset (rst_n low at posedge), including mid-operation:
  - RegWrite=0, write_reg=0, write_data=0.
  - FIFO emptied; queued entries are discarded, not written.
  - fifo_level=0, drop_count=0.
  - b_ready=0 while rst_n is low; it goes high in the first cycle after release.

## Test plan
- Reset, then a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle → next cycle RegWrite=1, write_reg=5, write_data=0xDEADBEEF; the following cycle RegWrite=0.
- Four B pushes (regs 8..11, data 0x80..0xB0) while A is busy with reg 3 for 6 cycles:
  - fifo_level reaches 4 and b_ready=0.
  - chk_reg_1=10 gives chk_busy_1=1.
  - When A goes idle, writes to 8, 9, 10, 11 appear on 4 consecutive cycles in order; fifo_level returns to 0.
- Full FIFO with A idle and b_valid held: 1 pop, b_ready rises, next push accepted; no entry lost or duplicated across 20 random cycles (scoreboard compare).
- Zero-register filtering:
  - a_reg=0 and b_reg=0 valid in the same cycle → no RegWrite, b handshake completes, drop_count +2.
  - 200 such cycles with CNT_W=8 → drop_count stays 255.
- Three B entries queued, rst_n pulsed low for 1 cycle mid-drain → RegWrite=0 during reset, fifo_level=0, no further writes of the discarded entries, b_ready=0 then 1.
- chk_reg_1=0 while a write to 0 is attempted → chk_busy_1=0 always.
